// File: rtl/async_fifo_rd_ctrl.sv
// rtl/async_fifo_rd_ctrl.sv - async FIFO read-domain controller with Gray pointer sync and FWFT output
module async_fifo_rd_ctrl #(
  parameter int DATASIZE  = 8,
  parameter int ADDRSIZE  = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  input  logic [DATASIZE-1:0] mem_rdata,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  input  logic                rready,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rcount
);

  localparam int PW = ADDRSIZE + 1;
  typedef logic [PW-1:0] ptr_t;

  // Threshold sized to the count so the almost-empty compare stays width-matched.
  localparam ptr_t AE_LIMIT = PW'(AE_THRESH);

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = '0;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  ptr_t                rq1_q, rq2_q;
  ptr_t                rbin_q, rptr_q;
  ptr_t                rcount_q;
  logic                rempty_q, raempty_q;
  logic [DATASIZE-1:0] rdata_q;
  logic                rvalid_q;

  logic fetch;
  ptr_t rbin_d, rgray_d, wbin_sync, rcount_d;

  // The output register may be refilled whenever it is empty or being drained this cycle.
  assign fetch     = !rempty_q && (!rvalid_q || rready);
  assign rbin_d    = rbin_q + {{ADDRSIZE{1'b0}}, fetch};
  assign rgray_d   = rbin_d ^ (rbin_d >> 1);
  assign wbin_sync = gray2bin(rq2_q);
  // A modular difference over PW bits keeps a full memory (pointers 2**ADDRSIZE apart) distinct from empty.
  assign rcount_d  = wbin_sync - rbin_d;

  // Two-flop synchronizer for the write pointer; wptr lands directly in rq1.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rq1_q <= '0;
      rq2_q <= '0;
    end else begin
      rq1_q <= wptr;
      rq2_q <= rq1_q;
    end
  end

  // Read pointer, empty/almost-empty flags and fill count, all looking one fetch ahead.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      rcount_q  <= '0;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rgray_d;
      rempty_q  <= (rgray_d == rq2_q);
      rcount_q  <= rcount_d;
      raempty_q <= (rcount_d <= AE_LIMIT);
    end
  end

  // FWFT output stage: load on fetch, drop valid only when drained with nothing to refill.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (fetch) begin
      rdata_q  <= mem_rdata;
      rvalid_q <= 1'b1;
    end else if (rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign rptr    = rptr_q;
  assign raddr   = rbin_q[ADDRSIZE-1:0];
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign rempty  = rempty_q;
  assign raempty = raempty_q;
  assign rcount  = rcount_q;

endmodule
